// File: rtl/adc_sample_capture_if.sv
// ---------------------------------------------------------------------------
// adc_sample_capture_if
// Output sample stream of the ADC capture block: a valid/ready handshake
// carrying one zero-extended unsigned sample per transfer.
//   sampleData  : sample value, driven by the master
//   sampleValid : sampleData holds a sample, driven by the master
//   sampleReady : downstream accepts the sample, driven by the slave
// A transfer happens on a rising clock edge where sampleValid & sampleReady.
// ---------------------------------------------------------------------------
interface adc_sample_capture_if #(
  parameter int OUT_WIDTH = 16
) ();
  logic [OUT_WIDTH-1:0] sampleData;
  logic                 sampleValid;
  logic                 sampleReady;

  modport master (output sampleData, output sampleValid, input sampleReady);
  modport slave  (input sampleData, input sampleValid, output sampleReady);
endinterface

// File: rtl/adc_sample_capture.sv
// ---------------------------------------------------------------------------
// adc_sample_capture
// ADC front-end capture for the LaserDisc RF sampler. The raw ADC bus is
// sampled on the falling clock edge; on the rising edge the block optionally
// substitutes a counting test pattern or boxcar-decimates, then presents the
// result over a valid/ready stream with sticky clip/overflow status.
// Ports:
//   clock, nReset : ADC sample clock, asynchronous active-low reset
//   adcDatabus    : raw unsigned ADC data, valid at the falling edge
//   enable        : capture enable; config is latched only while low
//   mode          : 0 pass-through, 1 test pattern, 2 decimate, 3 as 0
//   decimLog2     : decimation factor 2^decimLog2 in mode 2
//   clearStatus   : one-cycle clear of sticky flags and sampleCount
//   smp           : output stream (sampleData/sampleValid/sampleReady)
//   clipHigh/Low  : sticky, a raw capture was all ones / zero
//   overflow      : sticky, a result was dropped under backpressure
//   sampleCount   : results loaded into the output register (wraps)
// OUT_WIDTH should be at least ADC_WIDTH+7; a narrower build truncates the
// top of large decimated sums.
// ---------------------------------------------------------------------------
module adc_sample_capture #(
  parameter int ADC_WIDTH = 10,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic [ADC_WIDTH-1:0] adcDatabus,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [2:0]           decimLog2,
  input  logic                 clearStatus,
  adc_sample_capture_if.master smp,
  output logic                 clipHigh,
  output logic                 clipLow,
  output logic                 overflow,
  output logic [31:0]          sampleCount
);
  localparam int ACC_WIDTH = ADC_WIDTH + 7;
  localparam logic [ADC_WIDTH-1:0] ALL_ONES = {ADC_WIDTH{1'b1}};

  logic [ADC_WIDTH-1:0] raw_q;
  logic [1:0]           cfg_mode_q;
  logic [2:0]           cfg_decim_q;
  logic [ADC_WIDTH-1:0] pat_q;
  logic [ADC_WIDTH-1:0] s1_data_q;
  logic                 s1_valid_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_next_s;
  logic [6:0]           phase_q, phase_d, phase_next_s, phase_max_s;
  logic [ACC_WIDTH-1:0] s1_ext_s, res_data_s;
  logic                 res_valid_s, load_s;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 clip_hi_q, clip_hi_d, clip_lo_q, clip_lo_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          count_q, count_d;

  // Stage 0: capture the ADC bus on every falling edge
  always_ff @(negedge clock or negedge nReset) begin
    if (!nReset) begin
      raw_q <= '0;
    end else begin
      raw_q <= adcDatabus;
    end
  end

  // Config latch (open only while disabled) and stage 1 sample select
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cfg_mode_q  <= 2'd0;
      cfg_decim_q <= 3'd0;
      pat_q       <= '0;
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
    end else if (!enable) begin
      cfg_mode_q  <= mode;
      cfg_decim_q <= decimLog2;
      pat_q       <= '0;
      s1_valid_q  <= 1'b0;
    end else begin
      s1_data_q  <= (cfg_mode_q == 2'd1) ? pat_q : raw_q;
      s1_valid_q <= 1'b1;
      pat_q      <= pat_q + ADC_WIDTH'(1);
    end
  end

  // Stage 2: boxcar accumulator; non-decimating modes pass stage 1 through
  always_comb begin
    s1_ext_s     = ACC_WIDTH'(s1_data_q);
    // last phase index = 2^decimLog2 - 1, built as a right-shifted mask
    phase_max_s  = 7'h7F >> (3'd7 - cfg_decim_q);
    res_valid_s  = 1'b0;
    res_data_s   = s1_ext_s;
    acc_next_s   = acc_q;
    phase_next_s = phase_q;
    if (s1_valid_q && (cfg_mode_q == 2'd2)) begin
      if (phase_q == phase_max_s) begin
        res_valid_s  = 1'b1;
        res_data_s   = acc_q + s1_ext_s;
        acc_next_s   = '0;
        phase_next_s = 7'd0;
      end else begin
        acc_next_s   = acc_q + s1_ext_s;
        phase_next_s = phase_q + 7'd1;
      end
    end else if (s1_valid_q) begin
      res_valid_s = 1'b1;
    end else begin
      res_valid_s = 1'b0;
    end
    // disabling discards any partial sum
    if (!enable) begin
      acc_d   = '0;
      phase_d = 7'd0;
    end else begin
      acc_d   = acc_next_s;
      phase_d = phase_next_s;
    end
  end

  // Output load/handshake and sticky status; set events beat clearStatus
  always_comb begin
    load_s  = res_valid_s && (!valid_q || smp.sampleReady);
    data_d  = data_q;
    valid_d = valid_q;
    if (load_s) begin
      data_d  = OUT_WIDTH'(res_data_s);
      valid_d = 1'b1;
    end else if (valid_q && smp.sampleReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    ovf_d     = (res_valid_s && !load_s) ? 1'b1 : (clearStatus ? 1'b0 : ovf_q);
    clip_hi_d = (enable && (raw_q == ALL_ONES)) ? 1'b1 : (clearStatus ? 1'b0 : clip_hi_q);
    clip_lo_d = (enable && (raw_q == '0)) ? 1'b1 : (clearStatus ? 1'b0 : clip_lo_q);
    if (load_s) begin
      count_d = clearStatus ? 32'd1 : (count_q + 32'd1);
    end else begin
      count_d = clearStatus ? 32'd0 : count_q;
    end
  end

  // Register stage 2 state and all outputs
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      acc_q     <= '0;
      phase_q   <= 7'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      clip_hi_q <= 1'b0;
      clip_lo_q <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      clip_hi_q <= clip_hi_d;
      clip_lo_q <= clip_lo_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  assign smp.sampleData  = data_q;
  assign smp.sampleValid = valid_q;
  assign clipHigh        = clip_hi_q;
  assign clipLow         = clip_lo_q;
  assign overflow        = ovf_q;
  assign sampleCount     = count_q;
endmodule
